egr_tqu_mq: RTL



---
 rtl/egr_tqu_mq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/egr_tqu_mq.sv
// Multi-queue egress tag queuing unit: NUM_Q FIFOs carved from one flop array, with per-queue flush.
// Optional feature macro: EGR_TQU_MQ_AFULL_EN (registered per-queue almost-full flags).
module egr_tqu_mq #(
  parameter int unsigned NUM_Q    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TAG_W    = 20,
  parameter int unsigned AFULL_TH = 12,
  localparam int unsigned QID_W   = $clog2(NUM_Q),
  localparam int unsigned PTR_W   = $clog2(DEPTH),
  localparam int unsigned CNT_W   = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_valid,
  input  logic [QID_W-1:0]         enq_qid,
  input  logic [TAG_W-1:0]         enq_tag,
  output logic                     enq_ready,
  input  logic                     deq_req,
  input  logic [QID_W-1:0]         deq_qid,
  output logic                     deq_rsp_vld,
  output logic                     deq_rsp_empty,
  output logic [TAG_W-1:0]         deq_rsp_tag,
  input  logic                     flush_req,
  input  logic [QID_W-1:0]         flush_qid,
  output logic [NUM_Q*CNT_W-1:0]   q_cnt,
  output logic [NUM_Q-1:0]         q_afull
);

  localparam int unsigned AW      = QID_W + PTR_W;
  localparam int unsigned ENTRIES = NUM_Q * DEPTH;

  logic [TAG_W-1:0] mem_q [ENTRIES];

  logic [PTR_W-1:0] head_q [NUM_Q];
  logic [PTR_W-1:0] head_d [NUM_Q];
  logic [PTR_W-1:0] tail_q [NUM_Q];
  logic [PTR_W-1:0] tail_d [NUM_Q];
  logic [CNT_W-1:0] cnt_q  [NUM_Q];
  logic [CNT_W-1:0] cnt_d  [NUM_Q];

  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_empty_q, rsp_empty_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

  logic             enq_hit;
  logic             deq_hit;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic             enq_this;
  logic             deq_this;

  assign enq_ready = (cnt_q[enq_qid] != CNT_W'(DEPTH));
  assign waddr     = {enq_qid, tail_q[enq_qid]};
  assign raddr     = {deq_qid, head_q[deq_qid]};

  // A flush of the same queue wins over enqueue and dequeue in that cycle.
  always_comb begin
    enq_hit     = enq_valid && enq_ready && !(flush_req && (flush_qid == enq_qid));
    deq_hit     = deq_req && (cnt_q[deq_qid] != '0) && !(flush_req && (flush_qid == deq_qid));
    rsp_vld_d   = deq_req;
    rsp_empty_d = deq_req && !deq_hit;
    rsp_tag_d   = deq_hit ? mem_q[raddr] : '0;
    enq_this    = 1'b0;
    deq_this    = 1'b0;
    for (int q = 0; q < NUM_Q; q++) begin
      head_d[q] = head_q[q];
      tail_d[q] = tail_q[q];
      cnt_d[q]  = cnt_q[q];
      enq_this  = enq_hit && (enq_qid == QID_W'(q));
      deq_this  = deq_hit && (deq_qid == QID_W'(q));
      if (flush_req && (flush_qid == QID_W'(q))) begin
        head_d[q] = '0;
        tail_d[q] = '0;
        cnt_d[q]  = '0;
      end else begin
        if (enq_this) tail_d[q] = tail_q[q] + PTR_W'(1);
        if (deq_this) head_d[q] = head_q[q] + PTR_W'(1);
        cnt_d[q] = cnt_q[q] + CNT_W'(enq_this) - CNT_W'(deq_this);
      end
    end
  end

  // Tag storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rst_n && enq_hit) mem_q[waddr] <= enq_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int q = 0; q < NUM_Q; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
        cnt_q[q]  <= '0;
      end
      rsp_vld_q   <= 1'b0;
      rsp_empty_q <= 1'b0;
      rsp_tag_q   <= '0;
    end else begin
      for (int q = 0; q < NUM_Q; q++) begin
        head_q[q] <= head_d[q];
        tail_q[q] <= tail_d[q];
        cnt_q[q]  <= cnt_d[q];
      end
      rsp_vld_q   <= rsp_vld_d;
      rsp_empty_q <= rsp_empty_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

  assign deq_rsp_vld   = rsp_vld_q;
  assign deq_rsp_empty = rsp_empty_q;
  assign deq_rsp_tag   = rsp_tag_q;

  always_comb begin
    q_cnt = '0;
    for (int q = 0; q < NUM_Q; q++) q_cnt[q*CNT_W +: CNT_W] = cnt_q[q];
  end

`ifdef EGR_TQU_MQ_AFULL_EN
  logic [NUM_Q-1:0] afull_q, afull_d;

  always_comb begin
    afull_d = '0;
    for (int q = 0; q < NUM_Q; q++) afull_d[q] = (cnt_d[q] >= CNT_W'(AFULL_TH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) afull_q <= '0;
    else        afull_q <= afull_d;
  end

  assign q_afull = afull_q;
`else
  logic unused_afull_th;
  assign unused_afull_th = ^32'(AFULL_TH);
  assign q_afull         = '0;
`endif

endmodule
